// File: rtl/prog_clock_divider_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// Reset values and divisor saturation live here so channels agree.
package prog_clock_divider_pkg;

  localparam int   MIN_DIV        = 2;
  localparam logic RST_CLK_OUT    = 1'b0;
  localparam logic RST_TICK       = 1'b0;
  localparam logic RST_ACK        = 1'b0;
  localparam logic RST_PEND_VALID = 1'b0;

  // Clamp a requested divisor so the active value is never 0 or 1.
  function automatic logic [31:0] sat(input logic [31:0] x);
    return (x < 32'(MIN_DIV)) ? 32'(MIN_DIV) : x;
  endfunction

endpackage

// File: rtl/prog_clock_divider.sv
// Runtime-programmable clock divider with tick and load handshake.
// Build option: PROG_CLOCK_DIVIDER_RESTART_EN applies loads at once.
module prog_clock_divider
  import prog_clock_divider_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] div_i,
  input  logic             load_i,
  output logic             clk_out,
  output logic             tick_o,
  output logic             load_ack_o,
  output logic [WIDTH-1:0] div_act_o
);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_n_act;
  logic [WIDTH-1:0] r_pend;
  logic             r_pend_valid;
  logic             r_clk_out;
  logic             r_tick;
  logic             r_ack;

  logic [WIDTH-1:0] w_half;
  logic [WIDTH-1:0] w_div_sat;
  logic             w_wrap;
  logic             w_high;

  assign w_half    = r_n_act >> 1;
  assign w_div_sat = WIDTH'(sat(32'(div_i)));
  assign w_wrap    = (r_cnt == (r_n_act - ONE));
  assign w_high    = (r_cnt < w_half);

`ifdef PROG_CLOCK_DIVIDER_RESTART_EN

  // Count and restart the phase whenever a divisor is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_clk_out    <= RST_CLK_OUT;
      r_tick       <= RST_TICK;
      r_ack        <= RST_ACK;
      r_n_act      <= RST_DIV;
      r_pend       <= '0;
      r_pend_valid <= RST_PEND_VALID;
    end else begin
      r_tick <= 1'b0;
      r_ack  <= 1'b0;
      if (en && (load_i || r_pend_valid)) begin
        r_n_act      <= load_i ? w_div_sat : r_pend;
        r_pend_valid <= 1'b0;
        r_cnt        <= '0;
        r_clk_out    <= 1'b0;
        r_ack        <= 1'b1;
      end else if (en) begin
        r_clk_out <= w_high;
        r_cnt     <= w_wrap ? '0 : r_cnt + ONE;
        r_tick    <= w_wrap;
      end else if (load_i) begin
        // Frozen: hold the load until the first enabled edge.
        r_pend       <= w_div_sat;
        r_pend_valid <= 1'b1;
      end
    end
  end

`else

  // Count, and swap in a pending divisor only at a period wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_clk_out    <= RST_CLK_OUT;
      r_tick       <= RST_TICK;
      r_ack        <= RST_ACK;
      r_n_act      <= RST_DIV;
      r_pend       <= '0;
      r_pend_valid <= RST_PEND_VALID;
    end else begin
      r_tick <= 1'b0;
      r_ack  <= 1'b0;
      if (en) begin
        r_clk_out <= w_high;
        r_cnt     <= w_wrap ? '0 : r_cnt + ONE;
        r_tick    <= w_wrap;
        if (w_wrap && r_pend_valid) begin
          r_n_act      <= r_pend;
          r_pend_valid <= 1'b0;
          r_ack        <= 1'b1;
        end
      end
      // A load on the apply edge refills pend for the next wrap.
      if (load_i) begin
        r_pend       <= w_div_sat;
        r_pend_valid <= 1'b1;
      end
    end
  end

`endif

  assign clk_out    = r_clk_out;
  assign tick_o     = r_tick;
  assign load_ack_o = r_ack;
  assign div_act_o  = r_n_act;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Randomised scoreboard bench for prog_clock_divider.
// Model builds whole periods as high/low runs and replays them.
module tb_prog_clock_divider;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] div_i;
  logic       load_i;
  logic       clk_out;
  logic       tick_o;
  logic       load_ack_o;
  logic [7:0] div_act_o;

  int tests;
  int fails;

  typedef struct packed {
    logic c;
    logic t;
  } ph_t;

  typedef struct {
    logic       c;
    logic       t;
    logic       a;
    logic [7:0] d;
  } exp_t;

  ph_t  seq[$];
  exp_t sb[$];

  prog_clock_divider #(
    .WIDTH(8),
    .DEFAULT_DIV(10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .div_i     (div_i),
    .load_i    (load_i),
    .clk_out   (clk_out),
    .tick_o    (tick_o),
    .load_ack_o(load_ack_o),
    .div_act_o (div_act_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int satm(input int x);
    return (x < 2) ? 2 : x;
  endfunction

  // One full output period: n/2 high samples, then the rest low,
  // the final low sample carrying the wrap tick.
  task automatic gen_period(input int n);
    int h;
    h = n / 2;
    for (int i = 0; i < h; i++) seq.push_back('{c: 1'b1, t: 1'b0});
    for (int i = 0; i < n - h; i++)
      seq.push_back('{c: 1'b0, t: (i == n - h - 1)});
  endtask

  // Reference model: one expectation per clock edge.
  initial begin
    int   n;
    int   pend;
    bit   pv;
    logic last;
    logic c;
    logic t;
    logic a;
    ph_t  e;
    n = 10; pend = 0; pv = 0; last = 1'b0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        n = 10; pend = 0; pv = 0; last = 1'b0;
        seq.delete();
        sb.push_back('{c: 1'b0, t: 1'b0, a: 1'b0, d: 8'd10});
      end else begin
        c = last; t = 1'b0; a = 1'b0;
`ifdef PROG_CLOCK_DIVIDER_RESTART_EN
        if (en && (load_i || pv)) begin
          n = load_i ? satm(int'(div_i)) : pend;
          pv = 0;
          seq.delete();
          c = 1'b0;
          a = 1'b1;
        end else if (en) begin
          if (seq.size() == 0) gen_period(n);
          e = seq.pop_front();
          c = e.c;
          t = e.t;
        end else if (load_i) begin
          pend = satm(int'(div_i));
          pv = 1;
        end
`else
        if (en) begin
          if (seq.size() == 0) gen_period(n);
          e = seq.pop_front();
          c = e.c;
          t = e.t;
          if (t && pv) begin
            n = pend;
            pv = 0;
            a = 1'b1;
          end
        end
        if (load_i) begin
          pend = satm(int'(div_i));
          pv = 1;
        end
`endif
        last = c;
        sb.push_back('{c: c, t: t, a: a, d: 8'(n)});
      end
    end
  end

  // Monitor: compare DUT outputs shortly after every edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        x = sb.pop_front();
        tests++;
        if (clk_out !== x.c || tick_o !== x.t ||
            load_ack_o !== x.a || div_act_o !== x.d) begin
          fails++;
          $display("FAIL cycle t=%0t got clk=%b tick=%b ack=%b div=%0d exp clk=%b tick=%b ack=%b div=%0d",
                   $time, clk_out, tick_o, load_ack_o, div_act_o,
                   x.c, x.t, x.a, x.d);
        end
      end
    end
  end

  task automatic step(input logic e, input logic l, input int d);
    @(negedge clk);
    en = e;
    load_i = l;
    div_i = 8'(d);
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) step(1'b1, 1'b0, 0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    en = 1'b0;
    load_i = 1'b0;
    div_i = 8'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run(32);
    step(1'b1, 1'b1, 4);
    run(24);
    step(1'b1, 1'b1, 7);
    run(24);
    step(1'b1, 1'b1, 0);
    run(12);
    step(1'b1, 1'b1, 1);
    run(12);
    step(1'b1, 1'b1, 12);
    run(5);
    step(1'b1, 1'b1, 6);
    step(1'b1, 1'b1, 3);
    run(20);
    step(1'b1, 1'b1, 10);
    run(13);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 5);
    run(25);

    for (int i = 0; i < 3000; i++) begin
      int d;
      d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                      : int'($urandom_range(0, 12));
      step($urandom_range(0, 7) != 0,
           $urandom_range(0, 19) == 0, d);
    end
    run(300);

    // Asynchronous reset mid-period with a load outstanding.
    step(1'b1, 1'b1, 5);
    @(negedge clk);
    load_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (clk_out !== 1'b0 || tick_o !== 1'b0 ||
        load_ack_o !== 1'b0 || div_act_o !== 8'd10) begin
      fails++;
      $display("FAIL async_reset got clk=%b tick=%b ack=%b div=%0d exp 0 0 0 10",
               clk_out, tick_o, load_ack_o, div_act_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(40);
    @(posedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
